// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the unified-memory port: FSM states,
// grant owner, RV32I load/store size codes and byte-enable shapes.
package riscv_mem_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    typedef enum logic {
        G_IF = 1'b0,
        G_D  = 1'b1
    } grant_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the memory port: enables, store replication,
// load shift/extend and the misaligned/illegal-size flag.
module lsu_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_bad
);

    logic [4:0]  w_shamt;
    logic [31:0] w_word;
    logic        w_sext;

    always_comb begin
        w_shamt = 5'd0;
        w_word  = i_rdata;
        w_sext  = ~i_funct3[2];
        o_be    = BE_WORD;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        o_bad   = 1'b0;
        case (i_funct3)
            F3_LB, F3_LBU: begin
                w_shamt = {i_addr_lo, 3'b000};
                w_word  = i_rdata >> w_shamt;
                o_be    = BE_BYTE << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_sext & w_word[7]}}, w_word[7:0]};
            end
            F3_LH, F3_LHU: begin
                // halfword lane is picked by addr[1]; addr[0] must be clear
                w_shamt = {i_addr_lo[1], 4'b0000};
                w_word  = i_rdata >> w_shamt;
                o_be    = BE_HALF << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{w_sext & w_word[15]}}, w_word[15:0]};
                o_bad   = i_addr_lo[0];
            end
            F3_LW: begin
                o_bad = |i_addr_lo;
            end
            default: begin
                o_bad = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported unified memory between instruction fetch
// and load/store, one transaction at a time with round-robin ties.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned AW      = 12,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [2:0]    d_funct3,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_ack,
    output logic          d_err,
    output logic [31:0]   d_rdata,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    state_t      r_state;
    grant_t      r_grant;
    grant_t      r_last;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [1:0]  r_lo;
    logic [2:0]  r_cnt;

    logic          w_idle;
    logic          w_any;
    logic          w_pick_d;
    logic [2:0]    w_f3;
    logic [1:0]    w_lo;
    logic [AW-3:0] w_hi;
    logic [3:0]    w_be;
    logic [31:0]   w_wd_al;
    logic [31:0]   w_rd;
    logic          w_bad;

    assign w_idle = (r_state == S_IDLE);
    assign w_any  = if_req | d_req;
    assign busy   = ~w_idle;

    // In IDLE the aligner sees the winner's live fields so the
    // error check and lane setup happen on the grant edge itself.
    always_comb begin
        w_pick_d = d_req & (~if_req | (r_last == G_IF));
        w_hi     = w_pick_d ? d_addr[AW-1:2] : if_addr[AW-1:2];
        if (w_idle) begin
            w_f3 = w_pick_d ? d_funct3 : F3_LW;
            w_lo = w_pick_d ? d_addr[1:0] : if_addr[1:0];
        end else begin
            w_f3 = (r_grant == G_D) ? r_f3 : F3_LW;
            w_lo = (r_grant == G_D) ? r_lo : 2'b00;
        end
    end

    lsu_lane_align u_align (
        .i_funct3  (w_f3),
        .i_addr_lo (w_lo),
        .i_wdata   (d_wdata),
        .i_rdata   (mem_rdata),
        .o_be      (w_be),
        .o_wdata   (w_wd_al),
        .o_rdata   (w_rd),
        .o_bad     (w_bad)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_grant   <= G_IF;
            r_last    <= G_IF;
            r_we      <= 1'b0;
            r_f3      <= 3'b000;
            r_lo      <= 2'b00;
            r_cnt     <= 3'd0;
            if_ack    <= 1'b0;
            if_rdata  <= 32'd0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= 32'd0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'd0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
        end else begin
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'd0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick_d ? G_D : G_IF;
                        r_last  <= w_pick_d ? G_D : G_IF;
                        r_we    <= w_pick_d & d_we;
                        r_f3    <= d_funct3;
                        r_lo    <= w_lo;
                        if (w_pick_d && w_bad) begin
                            r_state <= S_ERR;
                            d_ack   <= 1'b1;
                            d_err   <= 1'b1;
                        end else begin
                            r_state   <= S_ISSUE;
                            mem_cs    <= 1'b1;
                            mem_we    <= w_pick_d & d_we;
                            mem_addr  <= {w_hi, 2'b00};
                            mem_be    <= w_be;
                            mem_wdata <= w_pick_d ? w_wd_al : 32'd0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_we) begin
                        r_state <= S_DONE;
                        d_ack   <= 1'b1;
                    end else begin
                        r_state <= S_WAIT;
                        r_cnt   <= LAT_M1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= S_DONE;
                        if (r_grant == G_D) begin
                            d_ack   <= 1'b1;
                            d_rdata <= w_rd;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_DONE, S_ERR: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level model
// checked every cycle plus literal expectations for each scenario.
module tb_mem_port_arbiter;

    localparam int AW  = 12;
    localparam int LAT = 2;

    logic          CLK;
    logic          RST;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic          d_we;
    logic [2:0]    d_funct3;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_ack;
    logic          d_err;
    logic [31:0]   d_rdata;
    logic          mem_cs;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          busy;

    mem_port_arbiter #(.AW(AW), .MEM_LAT(LAT)) dut (
        .CLK(CLK), .RST(RST),
        .if_req(if_req), .if_addr(if_addr),
        .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // memory: byte-enabled writes, reads returned LAT cycles after cs
    logic [31:0] mem [0:1023];
    logic [31:0] pipe [LAT];
    assign mem_rdata = pipe[LAT-1];

    always @(posedge CLK) begin
        logic [31:0] w;
        int idx;
        idx = int'(mem_addr) / 4;
        if (mem_cs && mem_we) begin
            w = mem[idx];
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            mem[idx] <= w;
        end
        pipe[0] <= (mem_cs && !mem_we) ? mem[idx] : 32'hDEADBEEF;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit f_bad(input logic [2:0] f3, input int lo);
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1;
        if ((f3 == 1 || f3 == 5) && (lo % 2) != 0) return 1;
        if (f3 == 2 && lo != 0) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] f_be(input logic [2:0] f3, input int lo);
        if (f3 == 0 || f3 == 4) return 32'(1 << lo);
        if (f3 == 1 || f3 == 5) return 32'(3 << (lo / 2 * 2));
        return 32'd15;
    endfunction

    function automatic logic [31:0] f_wd(input logic [2:0] f3,
                                         input logic [31:0] wd);
        if (f3 == 0) return (wd % 256) * 32'h01010101;
        if (f3 == 1) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] f_load(input logic [2:0] f3, input int lo,
                                           input logic [31:0] w);
        logic [31:0] v;
        if (f3 == 0 || f3 == 4) begin
            v = (w / (32'd1 << (8 * lo))) % 256;
            if (f3 == 0 && v >= 128) v = v + 32'hFFFFFF00;
            return v;
        end
        if (f3 == 1 || f3 == 5) begin
            v = (w / (32'd1 << (16 * (lo / 2)))) % 65536;
            if (f3 == 1 && v >= 32768) v = v + 32'hFFFF0000;
            return v;
        end
        return w;
    endfunction

    // transaction-level model: one in-flight transfer with its timeline
    bit            en = 0;
    bit            zero_next = 0;
    bit            m_act = 0;
    bit            m_isd, m_we, m_err;
    bit            m_lastd = 0;
    logic [2:0]    m_f3;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wd;
    int            m_t, m_ackc;
    int            m_free = 0;
    bit            glog [$];

    always @(negedge CLK) begin
        bit e_cs, e_ia, e_da, e_busy;
        if (en) begin
            e_busy = m_act && cyc >= m_t && cyc <= m_ackc;
            e_cs   = m_act && !m_err && cyc == m_t;
            e_da   = m_act && m_isd && cyc == m_ackc;
            e_ia   = m_act && !m_isd && cyc == m_ackc;
            chk("busy", 32'(busy), 32'(e_busy));
            chk("mem_cs", 32'(mem_cs), 32'(e_cs));
            chk("d_ack", 32'(d_ack), 32'(e_da));
            chk("if_ack", 32'(if_ack), 32'(e_ia));
            chk("d_err", 32'(d_err), 32'(e_da && m_err));
            if (e_cs) begin
                chk("mem_we", 32'(mem_we), 32'(m_we));
                chk("mem_addr", 32'(mem_addr), 32'(m_addr) & ~32'd3);
                chk("mem_be", 32'(mem_be),
                    m_isd ? f_be(m_f3, int'(m_addr) % 4) : 32'd15);
                if (m_we) chk("mem_wdata", mem_wdata, f_wd(m_f3, m_wd));
            end
            if (e_da && !m_we && !m_err)
                chk("d_rdata", d_rdata,
                    f_load(m_f3, int'(m_addr) % 4, mem[int'(m_addr) / 4]));
            if (e_ia)
                chk("if_rdata", if_rdata, mem[int'(m_addr) / 4]);
            if (zero_next) begin
                chk("rst_if_rdata", if_rdata, 32'd0);
                chk("rst_d_rdata", d_rdata, 32'd0);
                chk("rst_mem_be", 32'(mem_be), 32'd0);
                chk("rst_mem_addr", 32'(mem_addr), 32'd0);
                chk("rst_mem_wdata", mem_wdata, 32'd0);
                chk("rst_mem_we", 32'(mem_we), 32'd0);
            end
            if (m_act && cyc == m_ackc) begin
                m_act  = 0;
                m_free = cyc + 1;
                glog.push_back(m_isd);
            end
        end
        zero_next = 0;
        if (RST) begin
            m_act     = 0;
            m_lastd   = 0;
            m_free    = cyc + 1;
            zero_next = 1;
            en        = 1;
        end else if (en && !m_act && cyc >= m_free && (if_req || d_req)) begin
            m_isd   = d_req && (!if_req || !m_lastd);
            m_lastd = m_isd;
            m_t     = cyc + 1;
            m_f3    = m_isd ? d_funct3 : 3'b010;
            m_addr  = m_isd ? d_addr : if_addr;
            m_we    = m_isd && d_we;
            m_wd    = d_wdata;
            m_err   = m_isd && f_bad(m_f3, int'(m_addr) % 4);
            m_ackc  = m_err ? m_t : (m_we ? m_t + 1 : m_t + LAT + 1);
            m_act   = 1;
        end
    end

    // observations from the last driven transaction, for literal pins
    int            i_lat, d_lat, ncs;
    logic [31:0]   i_rd, d_rd, cs_wd;
    logic [AW-1:0] cs_addr;
    logic [3:0]    cs_be;
    bit            d_er;

    task automatic setd(input bit we, input logic [2:0] f3,
                        input logic [AW-1:0] a, input logic [31:0] wd);
        d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
    endtask

    task automatic run(input bit di, input bit dd);
        int  c0;
        bit  ai, ad;
        @(posedge CLK); #2;
        c0 = cyc; ncs = 0; i_lat = -1; d_lat = -1; d_er = 0;
        if_req = di; d_req = dd;
        for (int k = 0; k < 60 && (if_req || d_req); k++) begin
            @(negedge CLK);
            ai = if_ack; ad = d_ack;
            if (mem_cs) begin
                ncs++; cs_addr = mem_addr; cs_be = mem_be; cs_wd = mem_wdata;
            end
            if (ai) begin i_lat = cyc - c0; i_rd = if_rdata; end
            if (ad) begin d_lat = cyc - c0; d_rd = d_rdata; d_er = d_err; end
            @(posedge CLK); #2;
            if (ai) if_req = 0;
            if (ad) d_req = 0;
        end
        checks++;
        if (if_req || d_req) begin
            errors++;
            $display("FAIL ack_timeout if_req=%0b d_req=%0b", if_req, d_req);
            if_req = 0; d_req = 0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        for (int k = 0; k < LAT; k++) pipe[k] = 32'hDEADBEEF;
        mem[12'h104 / 4] = 32'h00500093;
        mem[12'h0A0 / 4] = 32'h12F03456;
        RST = 1; if_req = 1; d_req = 1;
        if_addr = 12'h104; setd(0, 3'b010, 12'h0A0, 32'd0);

        // reset held two cycles with both requesters active
        repeat (2) @(posedge CLK);
        #2; if_req = 0; d_req = 0;
        @(negedge CLK);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_cs", 32'(mem_cs), 32'd0);
        chk("reset_acks", {30'd0, if_ack, d_ack}, 32'd0);
        @(posedge CLK); #2; RST = 0;

        // instruction fetch
        if_addr = 12'h104;
        run(1, 0);
        chk("if_lat", i_lat, 32'd4);
        chk("if_word", i_rd, 32'h00500093);
        chk("if_cs_addr", 32'(cs_addr), 32'h104);
        chk("if_cs_be", 32'(cs_be), 32'hF);
        chk("if_ncs", ncs, 32'd1);

        // sub-word loads from 0x12F03456
        setd(0, 3'b000, 12'h0A2, 32'd0); run(0, 1);
        chk("lb_a2", d_rd, 32'hFFFFFFF0);
        chk("lb_lat", d_lat, 32'd4);
        setd(0, 3'b100, 12'h0A2, 32'd0); run(0, 1);
        chk("lbu_a2", d_rd, 32'h000000F0);
        setd(0, 3'b001, 12'h0A2, 32'd0); run(0, 1);
        chk("lh_a2", d_rd, 32'h000012F0);
        chk("lh_be", 32'(cs_be), 32'hC);
        setd(0, 3'b101, 12'h0A0, 32'd0); run(0, 1);
        chk("lhu_a0", d_rd, 32'h00003456);
        setd(0, 3'b000, 12'h0A1, 32'd0); run(0, 1);
        chk("lb_a1", d_rd, 32'h00000034);

        // stores and read-back
        setd(1, 3'b000, 12'h0A3, 32'h0000005A); run(0, 1);
        chk("sb_lat", d_lat, 32'd2);
        chk("sb_be", 32'(cs_be), 32'h8);
        chk("sb_wdata", cs_wd, 32'h5A5A5A5A);
        setd(0, 3'b010, 12'h0A0, 32'd0); run(0, 1);
        chk("lw_after_sb", d_rd, 32'h5AF03456);
        setd(1, 3'b001, 12'h0A6, 32'h1234ABCD); run(0, 1);
        chk("sh_be", 32'(cs_be), 32'hC);
        chk("sh_wdata", cs_wd, 32'hABCDABCD);
        setd(0, 3'b001, 12'h0A6, 32'd0); run(0, 1);
        chk("lh_neg", d_rd, 32'hFFFFABCD);

        // ties after reset: D first, then strict alternation
        @(posedge CLK); #2; RST = 1;
        @(posedge CLK); #2; RST = 0;
        base = glog.size();
        if_addr = 12'h104; setd(0, 3'b010, 12'h0A0, 32'd0);
        repeat (3) run(1, 1);
        chk("tie_count", glog.size() - base, 32'd6);
        for (int i = 0; i < 6 && base + i < glog.size(); i++)
            chk("tie_order", 32'(glog[base+i]), (i % 2 == 0) ? 32'd1 : 32'd0);

        // error responses: no memory access, ack+err one cycle after grant
        setd(0, 3'b010, 12'h0A2, 32'd0); run(0, 1);
        chk("lw_mis_lat", d_lat, 32'd1);
        chk("lw_mis_err", 32'(d_er), 32'd1);
        chk("lw_mis_ncs", ncs, 32'd0);
        setd(0, 3'b011, 12'h0A0, 32'd0); run(0, 1);
        chk("f3_bad_err", 32'(d_er), 32'd1);
        chk("f3_bad_ncs", ncs, 32'd0);
        setd(1, 3'b001, 12'h0A1, 32'h1); run(0, 1);
        chk("sh_mis_err", 32'(d_er), 32'd1);

        // reset while waiting on a load: dropped with no ack
        setd(0, 3'b010, 12'h0A0, 32'd0);
        @(posedge CLK); #2; d_req = 1;
        @(posedge CLK); #2;
        @(posedge CLK); #2;
        @(negedge CLK);
        chk("wait_busy", 32'(busy), 32'd1);
        @(posedge CLK); #2; RST = 1; d_req = 0;
        @(posedge CLK); #2; RST = 0;
        begin
            int nack = 0;
            repeat (6) begin
                @(negedge CLK);
                if (d_ack || if_ack) nack++;
            end
            chk("rst_wait_noack", nack, 32'd0);
            chk("rst_wait_idle", 32'(busy), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
